// File: rtl/systick_sequencer.sv
// Bus initiator that programs system_timer, starts it and acknowledges its ticks in hardware.
// Optional macro SYSTICK_SEQ_SNAPSHOT_EN adds a VAL_L/VAL_H snapshot read after each acknowledge.
module systick_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic [63:0] cfg_load,
    input  logic        cfg_ie,
    output logic        busy,
    output logic        running,
    output logic        done,
    output logic        tick_pulse,
    output logic [31:0] tick_count,
    output logic        spurious,
    output logic [63:0] snap_val,
    output logic        sel,
    output logic [2:0]  addr,
    output logic [31:0] wdata,
    output logic        wen,
    input  logic [31:0] rdata,
    input  logic        irq
);

    localparam logic [2:0] CTRL_ADDR  = 3'b000;
    localparam logic [2:0] LOADL_ADDR = 3'b001;
    localparam logic [2:0] LOADH_ADDR = 3'b011;
    localparam logic [2:0] VALL_ADDR  = 3'b010;
    localparam logic [2:0] VALH_ADDR  = 3'b100;

`ifdef SYSTICK_SEQ_SNAPSHOT_EN
    typedef enum logic [3:0] {
        IDLE, W_OFF, W_LL, W_LH, W_VAL, W_ON, RUN, ACK, SNAP_L, SNAP_H, STOP
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, W_OFF, W_LL, W_LH, W_VAL, W_ON, RUN, ACK, STOP
    } state_t;
`endif

    state_t      state_q, state_d;
    logic        stop_pend_q, stop_pend_d;
    logic [63:0] load_q, load_d;
    logic        ie_q, ie_d;
    logic [31:0] tick_count_q, tick_count_d;
    logic        spurious_q, spurious_d;
    logic        tick_pulse_q, tick_pulse_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        running_q, running_d;
    logic        sel_q, sel_d;
    logic        wen_q, wen_d;
    logic [2:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        svc_end, svc_flag;

`ifdef SYSTICK_SEQ_SNAPSHOT_EN
    logic        flag_q, flag_d;
    logic [31:0] val_l_q, val_l_d;
    logic [63:0] snap_q, snap_d;
`else
    logic        unused_rdata;
    assign unused_rdata = ^{rdata[31:17], rdata[15:0]};
`endif

    always_comb begin
        state_d      = state_q;
        stop_pend_d  = stop_pend_q;
        load_d       = load_q;
        ie_d         = ie_q;
        tick_count_d = tick_count_q;
        spurious_d   = spurious_q;
        tick_pulse_d = 1'b0;
        done_d       = 1'b0;
        svc_end      = 1'b0;
        svc_flag     = 1'b0;
`ifdef SYSTICK_SEQ_SNAPSHOT_EN
        flag_d       = flag_q;
        val_l_d      = val_l_q;
        snap_d       = snap_q;
`endif
        // A stop arriving mid-sequence is remembered and honoured at the next safe point.
        if (cfg_stop && !(state_q inside {IDLE, RUN, STOP})) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d      = W_OFF;
                    load_d       = cfg_load;
                    ie_d         = cfg_ie;
                    tick_count_d = '0;
                    spurious_d   = 1'b0;
                    stop_pend_d  = 1'b0;
                end
            end
            W_OFF: state_d = W_LL;
            W_LL:  state_d = W_LH;
            W_LH:  state_d = W_VAL;
            W_VAL: state_d = W_ON;
            W_ON: begin
                done_d  = 1'b1;
                state_d = (stop_pend_q || cfg_stop) ? STOP : RUN;
            end
            RUN: begin
                if (irq) begin
                    state_d     = ACK;
                    stop_pend_d = cfg_stop;
                end else if (cfg_stop) begin
                    state_d = STOP;
                end
            end
`ifdef SYSTICK_SEQ_SNAPSHOT_EN
            ACK: begin
                flag_d  = rdata[16];
                state_d = SNAP_L;
            end
            SNAP_L: begin
                val_l_d = rdata;
                state_d = SNAP_H;
            end
            SNAP_H: begin
                svc_end  = 1'b1;
                svc_flag = flag_q;
                if (flag_q) begin
                    snap_d = {rdata, val_l_q};
                end
            end
`else
            ACK: begin
                svc_end  = 1'b1;
                svc_flag = rdata[16];
            end
`endif
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (svc_end) begin
            if (svc_flag) begin
                tick_pulse_d = 1'b1;
                tick_count_d = tick_count_q + 32'd1;
            end else begin
                spurious_d = 1'b1;
            end
            state_d = (stop_pend_q || cfg_stop) ? STOP : RUN;
        end
        if (state_d == STOP) begin
            stop_pend_d = 1'b0;
        end

        // Bus outputs are registered from the next state so each access lasts exactly one cycle.
        sel_d   = 1'b0;
        wen_d   = 1'b0;
        addr_d  = VALL_ADDR;
        wdata_d = '0;
        case (state_d)
            W_OFF: begin sel_d = 1'b1; wen_d = 1'b1; addr_d = CTRL_ADDR; end
            W_LL:  begin sel_d = 1'b1; wen_d = 1'b1; addr_d = LOADL_ADDR; wdata_d = load_q[31:0]; end
            W_LH:  begin sel_d = 1'b1; wen_d = 1'b1; addr_d = LOADH_ADDR; wdata_d = load_q[63:32]; end
            W_VAL: begin sel_d = 1'b1; wen_d = 1'b1; addr_d = VALL_ADDR; end
            W_ON:  begin sel_d = 1'b1; wen_d = 1'b1; addr_d = CTRL_ADDR; wdata_d = {30'b0, ie_q, 1'b1}; end
            ACK:   begin sel_d = 1'b1; addr_d = CTRL_ADDR; end
`ifdef SYSTICK_SEQ_SNAPSHOT_EN
            SNAP_L: begin sel_d = 1'b1; addr_d = VALL_ADDR; end
            SNAP_H: begin sel_d = 1'b1; addr_d = VALH_ADDR; end
`endif
            STOP:  begin sel_d = 1'b1; wen_d = 1'b1; addr_d = CTRL_ADDR; end
            default: ;
        endcase

        busy_d    = state_d inside {W_OFF, W_LL, W_LH, W_VAL, W_ON, STOP};
`ifdef SYSTICK_SEQ_SNAPSHOT_EN
        running_d = state_d inside {RUN, ACK, SNAP_L, SNAP_H};
`else
        running_d = state_d inside {RUN, ACK};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            stop_pend_q  <= 1'b0;
            tick_count_q <= '0;
            spurious_q   <= 1'b0;
            tick_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            running_q    <= 1'b0;
            sel_q        <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= VALL_ADDR;
            wdata_q      <= '0;
`ifdef SYSTICK_SEQ_SNAPSHOT_EN
            snap_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            stop_pend_q  <= stop_pend_d;
            tick_count_q <= tick_count_d;
            spurious_q   <= spurious_d;
            tick_pulse_q <= tick_pulse_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            running_q    <= running_d;
            sel_q        <= sel_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef SYSTICK_SEQ_SNAPSHOT_EN
            snap_q       <= snap_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        load_q  <= load_d;
        ie_q    <= ie_d;
`ifdef SYSTICK_SEQ_SNAPSHOT_EN
        flag_q  <= flag_d;
        val_l_q <= val_l_d;
`endif
    end

    assign busy       = busy_q;
    assign running    = running_q;
    assign done       = done_q;
    assign tick_pulse = tick_pulse_q;
    assign tick_count = tick_count_q;
    assign spurious   = spurious_q;
    assign sel        = sel_q;
    assign wen        = wen_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
`ifdef SYSTICK_SEQ_SNAPSHOT_EN
    assign snap_val   = snap_q;
`else
    assign snap_val   = '0;
`endif

endmodule
